// File: rtl/tick_timer_pkg.sv
// Shared types and helpers for the tick timer scheduler.
package tick_timer_pkg;

   typedef enum logic {T_IDLE, T_RUN} tmr_state_t;

   localparam int DEF_CNT_W = 16;

   // Channel-select width; a single channel still gets a 1-bit index.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: registered one-cycle tick every PRESCALE clocks.
module tick_prescaler #(
   parameter int PRESCALE = 8
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt, cnt_nxt;

   always_comb cnt_nxt = (cnt == LAST) ? '0 : cnt + 1'b1;

   // tick is registered so it is high exactly while cnt == PRESCALE-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         tick <= (cnt_nxt == LAST);
      end
   end

endmodule

// File: rtl/tick_timer_scheduler.sv
// CHANNELS countdown timers sharing one prescaled tick; sticky irq per channel.
// Optional TIMER_OVERRUN_EN adds an overrun flag for expiries on an unacked irq.
module tick_timer_scheduler
   import tick_timer_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int PRESCALE = 8,
   parameter int CNT_W    = DEF_CNT_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [ch_w(CHANNELS)-1:0]  wr_ch,
   input  logic [CNT_W-1:0]           wr_count,
   input  logic                       wr_periodic,
   input  logic [CHANNELS-1:0]        ack,
   output logic                       tick,
   output logic [CHANNELS-1:0]        busy,
   output logic [CHANNELS-1:0]        irq
`ifdef TIMER_OVERRUN_EN
   ,
   output logic [CHANNELS-1:0]        overrun
`endif
);

   localparam int CH_W = ch_w(CHANNELS);

   tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      tmr_state_t       st;
      logic [CNT_W-1:0] rem, rld;
      logic             per, irq_q, hit, expire;

      // Out-of-range indices match no channel and are dropped.
      assign hit    = wr_en && (wr_ch == CH_W'(i));
      // A write in the same cycle swallows the tick.
      assign expire = (st == T_RUN) && tick && !hit && (rem == CNT_W'(1));

      always_ff @(posedge clk) begin
         if (rst) begin
            st    <= T_IDLE;
            rem   <= '0;
            rld   <= '0;
            per   <= 1'b0;
            irq_q <= 1'b0;
         end else begin
            if (hit) begin
               if (wr_count != '0) begin
                  st  <= T_RUN;
                  rem <= wr_count;
                  rld <= wr_count;
                  per <= wr_periodic;
               end else begin
                  st  <= T_IDLE;
               end
            end else if (st == T_RUN && tick) begin
               if (rem > CNT_W'(1))
                  rem <= rem - 1'b1;
               else if (per)
                  rem <= rld;
               else
                  st  <= T_IDLE;
            end

            if (expire)
               irq_q <= 1'b1;
            else if (ack[i])
               irq_q <= 1'b0;
         end
      end

      assign busy[i] = (st == T_RUN);
      assign irq[i]  = irq_q;

`ifdef TIMER_OVERRUN_EN
      logic ovr_q;
      always_ff @(posedge clk) begin
         if (rst)
            ovr_q <= 1'b0;
         else if (expire && irq_q)
            ovr_q <= 1'b1;
         else if (ack[i])
            ovr_q <= 1'b0;
      end
      assign overrun[i] = ovr_q;
`endif
   end

endmodule

// File: tb/tb_tick_timer_scheduler.sv
// Directed bench for tick_timer_scheduler with PRESCALE=4, CHANNELS=4.
module tb_tick_timer_scheduler;

   localparam int CH = 4;
   localparam int PS = 4;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic [1:0]    wr_ch = '0;
   logic [CW-1:0] wr_count = '0;
   logic          wr_periodic = 1'b0;
   logic [CH-1:0] ack = '0;
   logic          tick;
   logic [CH-1:0] busy, irq;
`ifdef TIMER_OVERRUN_EN
   logic [CH-1:0] overrun;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   tick_timer_scheduler #(.CHANNELS(CH), .PRESCALE(PS), .CNT_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_ch       (wr_ch),
      .wr_count    (wr_count),
      .wr_periodic (wr_periodic),
      .ack         (ack),
      .tick        (tick),
      .busy        (busy),
      .irq         (irq)
`ifdef TIMER_OVERRUN_EN
      ,
      .overrun     (overrun)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input int ch, input int cnt, input logic p);
      wr_en       = 1'b1;
      wr_ch       = ch[1:0];
      wr_count    = CW'(cnt);
      wr_periodic = p;
      step();
      wr_en       = 1'b0;
   endtask

   task automatic wait_tick();
      int k = 0;
      while (tick !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      if (k >= 20) chk("tick_timeout", 32'(k), 0);
   endtask

   task automatic wait_irq(input int ch, input int lim, output int k);
      k = 0;
      while (irq[ch] !== 1'b1 && k < lim) begin
         step();
         k++;
      end
   endtask

   initial begin
      int   k;
      logic pb;
      logic seen;

      // reset state
      step(2);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_irq", 32'(irq), 0);
      chk("rst_tick", 32'(tick), 0);
      rst = 1'b0;

      // tick period
      wait_tick();
      k = 0;
      do begin
         step();
         k++;
      end while (tick !== 1'b1 && k < 20);
      chk("tick_period", 32'(k), PS);

      // 1: one-shot count=3 written just after a tick
      step();
      wr(0, 3, 1'b0);
      chk("t1_busy_on", 32'(busy[0]), 1);
      k  = 0;
      pb = 1'b0;
      while (irq[0] !== 1'b1 && k < 30) begin
         pb = busy[0];
         step();
         k++;
      end
      chk("t1_latency", 32'(k), 11);
      chk("t1_busy_prev", 32'(pb), 1);
      chk("t1_busy_off", 32'(busy[0]), 0);

      // 2: periodic count=2 on ch1, ack each expiry
      wr(1, 2, 1'b1);
      wait_irq(1, 40, k);
      chk("t2_first", 32'(irq[1]), 1);
      for (int r = 0; r < 2; r++) begin
         ack[1] = 1'b1;
         step();
         ack[1] = 1'b0;
         chk("t2_ackclr", 32'(irq[1]), 0);
         wait_irq(1, 40, k);
         chk("t2_period", 32'(k + 1), 8);
      end
      ack[1] = 1'b1;
      step();
      ack[1] = 1'b0;
      wr(1, 0, 1'b0);
      chk("t2_cancel", 32'(busy[1]), 0);

      // 3: cancel ch2 after two ticks
      wr(2, 5, 1'b0);
      wait_tick();
      step();
      wait_tick();
      step();
      wr(2, 0, 1'b0);
      chk("t3_busy", 32'(busy[2]), 0);
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (irq[2] === 1'b1 || busy[2] === 1'b1) seen = 1'b1;
      end
      chk("t3_no_irq", 32'(seen), 0);

      // 4: write coincident with tick starts fresh
      wait_tick();
      wr(3, 2, 1'b0);
      wait_irq(3, 30, k);
      chk("t4_fresh", 32'(k), 8);

      // 4b: ack held through an expiry; set wins
      ack[0] = 1'b1;
      step();
      chk("t4_pre_clr", 32'(irq[0]), 0);
      wr(0, 2, 1'b0);
      k = 0;
      while (busy[0] === 1'b1 && k < 20) begin
         step();
         k++;
      end
      chk("t4_ack_vs_set", 32'(irq[0]), 1);
      step();
      ack[0] = 1'b0;
      chk("t4_ack_after", 32'(irq[0]), 0);

`ifdef TIMER_OVERRUN_EN
      // 5: overrun on the second unacked expiry
      ack = '1;
      step();
      ack = '0;
      wr(0, 1, 1'b1);
      wait_irq(0, 20, k);
      chk("t5_irq", 32'(irq[0]), 1);
      chk("t5_ovr_first", 32'(overrun[0]), 0);
      step(3);
      chk("t5_ovr_early", 32'(overrun[0]), 0);
      step();
      chk("t5_ovr_set", 32'(overrun[0]), 1);
      wr(0, 0, 1'b0);
      ack[0] = 1'b1;
      step();
      ack[0] = 1'b0;
      chk("t5_irq_clr", 32'(irq[0]), 0);
      chk("t5_ovr_clr", 32'(overrun[0]), 0);
`endif

      // 6: reset mid-run
      ack = '1;
      step();
      ack = '0;
      wr(0, 100, 1'b0);
      wr(1, 100, 1'b1);
      wr(2, 100, 1'b0);
      chk("t6_busy", 32'(busy), 32'h7);
      step(5);
      rst = 1'b1;
      step();
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_irq", 32'(irq), 0);
      chk("t6_rst_tick", 32'(tick), 0);
      rst = 1'b0;
      k = 0;
      while (tick !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      chk("t6_tick_resume", 32'(k), PS - 1);
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (irq !== '0 || busy !== '0) seen = 1'b1;
      end
      chk("t6_quiet", 32'(seen), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
